// File: rtl/lcd_bus_driver.sv
// HD44780 write-cycle sequencer: power-up wait, optional controller init, then one timed write per handshake.
// Define LCD_INIT_SEQ_EN to run the built-in six-command init sequence after power-up.
module lcd_bus_driver #(
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int POWERUP_CYC    = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
);

    // state   | meaning
    // POWERUP | post-reset wait before the panel accepts writes
    // LOAD    | place the next init ROM byte on the bus
    // SETUP   | RS/DATA settling, EN low
    // ENH     | EN strobe high
    // WAIT    | controller execution time, EN low
    // IDLE    | ready for a host byte
    typedef enum logic [2:0] {
        POWERUP = 3'd0,
`ifdef LCD_INIT_SEQ_EN
        LOAD    = 3'd1,
`endif
        SETUP   = 3'd2,
        ENH     = 3'd3,
        WAIT    = 3'd4,
        IDLE    = 3'd5
    } state_t;

    localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LD    = 20'(EN_HIGH_CYC - 1);
    localparam logic [19:0] CMD_LD   = 20'(CMD_WAIT_CYC - 1);
    localparam logic [19:0] CLEAR_LD = 20'(CLEAR_WAIT_CYC - 1);
    // The first power-up cycle arms the counter, so it loads one less than a normal phase.
    localparam logic [19:0] PU_LD    = 20'((POWERUP_CYC > 1) ? (POWERUP_CYC - 2) : 0);
    localparam bit          PU_ONE   = (POWERUP_CYC == 1);
`ifdef LCD_INIT_SEQ_EN
    localparam state_t      PU_NEXT  = LOAD;
`else
    localparam state_t      PU_NEXT  = IDLE;
`endif

    state_t      state;
    state_t      next_state;
    logic [19:0] cnt;
    logic        pu_armed;
    logic        cnt_zero;
    logic        is_clear;
    logic        accept;
`ifdef LCD_INIT_SEQ_EN
    logic [2:0]  init_idx;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            default:          init_rom = 8'h06;
        endcase
    endfunction
`endif

    assign cnt_zero = (cnt == 20'd0);
    assign is_clear = !LCD_RS && ((LCD_DATA == 8'h01) || (LCD_DATA == 8'h02));
    assign accept   = in_valid && in_ready;
    assign LCD_RW   = 1'b0;

    always_ff @(posedge Clock) begin
        if (Reset) state <= POWERUP;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            POWERUP: if (pu_armed ? cnt_zero : PU_ONE) next_state = PU_NEXT;
`ifdef LCD_INIT_SEQ_EN
            LOAD:    next_state = SETUP;
`endif
            SETUP:   if (cnt_zero) next_state = ENH;
            ENH:     if (cnt_zero) next_state = WAIT;
`ifdef LCD_INIT_SEQ_EN
            WAIT:    if (cnt_zero) next_state = (init_done || init_idx == 3'd5) ? IDLE : LOAD;
`else
            WAIT:    if (cnt_zero) next_state = IDLE;
`endif
            IDLE:    if (accept) next_state = SETUP;
            default: next_state = POWERUP;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && init_done;
        busy     = (state != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt       <= '0;
            pu_armed  <= 1'b0;
            init_done <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
            init_idx  <= 3'd0;
`endif
        end else begin
            LCD_EN <= (next_state == ENH);

            if (state == POWERUP && !pu_armed) begin
                pu_armed <= 1'b1;
                cnt      <= PU_LD;
            end else if (next_state != state) begin
                case (next_state)
                    SETUP:   cnt <= SETUP_LD;
                    ENH:     cnt <= EN_LD;
                    WAIT:    cnt <= is_clear ? CLEAR_LD : CMD_LD;
                    default: cnt <= '0;
                endcase
            end else if (!cnt_zero) begin
                cnt <= cnt - 20'd1;
            end

`ifdef LCD_INIT_SEQ_EN
            if (state == WAIT && cnt_zero && !init_done) begin
                if (init_idx == 3'd5) init_done <= 1'b1;
                else                  init_idx  <= init_idx + 3'd1;
            end
`else
            if (state == POWERUP && next_state == IDLE) init_done <= 1'b1;
`endif

            if (accept) begin
                LCD_RS   <= in_rs;
                LCD_DATA <= in_data;
            end
`ifdef LCD_INIT_SEQ_EN
            else if (state == LOAD) begin
                LCD_RS   <= 1'b0;
                LCD_DATA <= init_rom(init_idx);
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver: bus pulses are logged and compared with timings derived from the write rules.
module tb_lcd_bus_driver;

    localparam int S  = 2;
    localparam int E  = 4;
    localparam int CW = 10;
    localparam int CL = 30;
    localparam int PU = 20;
`ifdef LCD_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy, init_done, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_DATA;

    lcd_bus_driver #(
        .SETUP_CYC(S), .EN_HIGH_CYC(E), .CMD_WAIT_CYC(CW),
        .CLEAR_WAIT_CYC(CL), .POWERUP_CYC(PU)
    ) dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_data(in_data), .busy(busy), .init_done(init_done),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
    );

    always #5 Clock = ~Clock;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         rise_q[$];
    int         wid_q[$];
    logic       rs_q[$];
    logic [7:0] dat_q[$];
    logic       en_q = 1'b0;
    int         cur_w = 0;
    int         unstable = 0;
    logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] msg [8] = '{8'h43, 8'h52, 8'h43, 8'h20, 8'h30, 8'h31, 8'h32, 8'h33};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? CL : CW;
    endfunction

    // One clock; samples 1 time unit after the edge and logs EN pulses.
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if (LCD_EN && !en_q) begin
            rise_q.push_back(cyc);
            rs_q.push_back(LCD_RS);
            dat_q.push_back(LCD_DATA);
            cur_w = 1;
        end else if (LCD_EN) begin
            cur_w++;
            if (LCD_DATA !== dat_q[$] || LCD_RS !== rs_q[$]) unstable++;
        end
        if (!LCD_EN && en_q) wid_q.push_back(cur_w);
        en_q = LCD_EN;
    endtask

    task automatic clear_log();
        rise_q.delete();
        wid_q.delete();
        rs_q.delete();
        dat_q.delete();
        unstable = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en"}, LCD_EN, 0);
        chk({tag, "_rs"}, LCD_RS, 0);
        chk({tag, "_rw"}, LCD_RW, 0);
        chk({tag, "_data"}, LCD_DATA, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_init_done"}, init_done, 0);
    endtask

    // Called in cycle 0, the first cycle with Reset low.
    task automatic check_init(input string tag);
        int t, idone_cyc, exp_n;
        int exp_rise [6];
        clear_log();
        idone_cyc = -1;
        t = PU;
        for (int k = 0; k < 6; k++) begin
            exp_rise[k] = t + 1 + S;
            t += 1 + S + E + wait_of(1'b0, init_seq[k]);
        end
        if (!INIT_EN) t = PU;
        exp_n = INIT_EN ? 6 : 0;
        while (!in_ready && cyc < 2000) begin
            if (init_done && idone_cyc < 0) idone_cyc = cyc;
            tick();
        end
        if (init_done && idone_cyc < 0) idone_cyc = cyc;
        chk({tag, "_ready_cyc"}, cyc, t);
        chk({tag, "_init_done_cyc"}, idone_cyc, t);
        chk({tag, "_pulse_count"}, rise_q.size(), exp_n);
        for (int k = 0; k < exp_n && k < rise_q.size(); k++) begin
            chk($sformatf("%s_rise%0d", tag, k), rise_q[k], exp_rise[k]);
            chk($sformatf("%s_width%0d", tag, k), (k < wid_q.size()) ? wid_q[k] : 0, E);
            chk($sformatf("%s_rs%0d", tag, k), rs_q[k], 0);
            chk($sformatf("%s_data%0d", tag, k), dat_q[k], init_seq[k]);
        end
        chk({tag, "_stable"}, unstable, 0);
    endtask

    // Called in a cycle where in_ready is already high.
    task automatic host_write(input string tag, input logic rs, input logic [7:0] d);
        int t;
        clear_log();
        t = cyc;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_rs    = 1'($urandom);
        in_data  = 8'($urandom);
        chk({tag, "_ready_drop"}, in_ready, 0);
        chk({tag, "_rs"}, LCD_RS, rs);
        chk({tag, "_data"}, LCD_DATA, d);
        while (!in_ready && cyc < t + 200) tick();
        chk({tag, "_ready_cyc"}, cyc, t + 1 + S + E + wait_of(rs, d));
        chk({tag, "_data_hold"}, LCD_DATA, d);
        chk({tag, "_rw"}, LCD_RW, 0);
        chk({tag, "_pulses"}, rise_q.size(), 1);
        if (rise_q.size() > 0) chk({tag, "_rise"}, rise_q[0], t + 1 + S);
        if (wid_q.size() > 0)  chk({tag, "_width"}, wid_q[0], E);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: cycle %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int bad, t;
        logic       rs;
        logic [7:0] d;

        repeat (3) tick();
        check_reset_vals("reset");
        Reset = 1'b0;
        cyc = 0;
        check_init("init");

        host_write("data_41", 1'b1, 8'h41);
        host_write("clear_cmd", 1'b0, 8'h01);
        host_write("clear_as_data", 1'b1, 8'h01);
        host_write("home_cmd", 1'b0, 8'h02);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            host_write($sformatf("rand%0d", i), rs, d);
        end

        // Burst: in_valid held high, bus inputs scrambled while busy.
        clear_log();
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_rs   = 1'b1;
            in_data = msg[i];
            t = cyc;
            tick();
            while (!in_ready && cyc < t + 200) begin
                if (LCD_DATA !== msg[i] || LCD_RS !== 1'b1) bad++;
                in_rs   = 1'($urandom);
                in_data = 8'($urandom);
                tick();
            end
            chk($sformatf("burst_ready_cyc%0d", i), cyc, t + 1 + S + E + CW);
            if (i == 7) in_valid = 1'b0;
        end
        repeat (40) tick();
        chk("burst_hold", bad, 0);
        chk("burst_pulses", rise_q.size(), 8);
        for (int i = 0; i < 8 && i < dat_q.size(); i++)
            chk($sformatf("burst_data%0d", i), dat_q[i], msg[i]);
        chk("burst_stable", unstable, 0);

        // Reset while EN is high.
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        t = cyc;
        while (!LCD_EN && cyc < t + 50) tick();
        chk("midpulse_en_seen", LCD_EN, 1);
        Reset = 1'b1;
        tick();
        check_reset_vals("midpulse");
        repeat (2) tick();
        Reset = 1'b0;
        cyc = 0;
        check_init("reinit");
        host_write("post_reinit", 1'b1, 8'h7E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
